// File: rtl/neopix_tx.sv
// neopix_tx: serialises a frame of 24-bit GRB pixels onto a WS2812 data line.
//
// Fetches one pixel per LED from an external colour store, using a
// request/address handshake. It sends each pixel MSB first (G7 .. B0), then
// holds the line low for the latch interval.
//
// Parameters
//   NUM_LEDS      maximum LEDs per frame (>= 2)
//   SYSTEM_CLOCK  clk_i frequency in Hz
// Ports
//   clk_i           clock, rising edge
//   reset_i         asynchronous active-high reset
//   start_i         frame start request, sampled while idle
//   led_count_i     LEDs to send this frame (clamped to NUM_LEDS)
//   red_i/green_i/blue_i  colour of the pixel at address_o, sampled in LOAD
//   busy_o          frame in progress
//   data_request_o  one-cycle fetch pulse for the pixel at address_o
//   address_o       current LED index
//   do_o            WS2812 serial output
// Build option
//   NEOPIX_TX_FULL_CHAIN_EN  when defined, every frame is NUM_LEDS long and
//                            led_count_i is ignored.
module neopix_tx #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned SYSTEM_CLOCK = 50000000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic [$clog2(NUM_LEDS):0]   led_count_i,
  input  logic [7:0]                  red_i,
  input  logic [7:0]                  green_i,
  input  logic [7:0]                  blue_i,
  output logic                        busy_o,
  output logic                        data_request_o,
  output logic [$clog2(NUM_LEDS)-1:0] address_o,
  output logic                        do_o
);

  localparam int unsigned AW     = $clog2(NUM_LEDS);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned TBIT   = SYSTEM_CLOCK / 800000;
  localparam int unsigned T0H    = SYSTEM_CLOCK / 2500000;
  localparam int unsigned T1H    = SYSTEM_CLOCK / 1250000;
  localparam int unsigned TLATCH = SYSTEM_CLOCK / 12500;
  localparam int unsigned TMAX   = (TLATCH > TBIT) ? TLATCH : TBIT;
  localparam int unsigned TW     = $clog2(TMAX + 1);
  localparam int unsigned BW     = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_REQ   = 3'd2,
    S_LOAD  = 3'd3,
    S_BIT   = 3'd4,
    S_LATCH = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [23:0]   shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          req_q, req_d;
  logic          do_q, do_d;

  logic [CW-1:0] n_start_c;
  logic          more_c;
  logic          bit_end_c;
  logic          word_end_c;
  logic          latch_end_c;

  // Frame length captured at the start edge.
`ifdef NEOPIX_TX_FULL_CHAIN_EN
  logic unused_count_c;
  assign unused_count_c = ^led_count_i;
  assign n_start_c      = CW'(NUM_LEDS);
`else
  assign n_start_c = (led_count_i > CW'(NUM_LEDS)) ? CW'(NUM_LEDS) : led_count_i;
`endif

  // Another LED follows the one currently addressed.
  assign more_c      = (CW'(addr_q) + CW'(1)) < n_q;
  assign bit_end_c   = (cyc_q == TW'(TBIT - 1));
  assign word_end_c  = bit_end_c && (bit_q == BW'(23));
  assign latch_end_c = (cyc_q == TW'(TLATCH - 1));

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      do_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      do_q    <= do_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (n_start_c == '0) ? S_LATCH : S_PREP;
        end
      end
      S_PREP:  state_d = S_REQ;
      S_REQ:   state_d = S_LOAD;
      S_LOAD:  state_d = S_BIT;
      S_BIT: begin
        if (word_end_c) begin
          state_d = last_q ? S_LATCH : S_REQ;
        end
      end
      S_LATCH: begin
        if (latch_end_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates; outputs are registered from the next state so they
  // line up with the state they belong to.
  always_comb begin
    n_d     = n_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        bit_d  = '0;
        cyc_d  = '0;
        if (start_i) begin
          n_d = n_start_c;
        end
      end
      S_LOAD: begin
        shift_d = {green_i, red_i, blue_i};
        bit_d   = '0;
        cyc_d   = '0;
        // Address moves on only when another pixel is still to be fetched,
        // so it never exceeds N-1; last_q remembers which word is final.
        last_d  = !more_c;
        if (more_c) begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_BIT: begin
        if (bit_end_c) begin
          cyc_d   = '0;
          bit_d   = bit_q + BW'(1);
          shift_d = {shift_q[22:0], 1'b0};
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      S_LATCH: begin
        if (latch_end_c) begin
          cyc_d  = '0;
          addr_d = '0;
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      default: begin
      end
    endcase

    busy_d = (state_d != S_IDLE);
    req_d  = (state_d == S_REQ);
    do_d   = (state_d == S_BIT) &&
             (cyc_d < (shift_d[23] ? TW'(T1H) : TW'(T0H)));
  end

  assign busy_o         = busy_q;
  assign data_request_o = req_q;
  assign address_o      = addr_q;
  assign do_o           = do_q;

endmodule

// File: tb/tb_neopix_tx.sv
// Bench for neopix_tx: random pixel colours served by a one-cycle-latency
// colour store; the serial line is decoded back into pixel words and
// timing offsets and compared against the expected frame.
`timescale 1ns/1ps
module tb_neopix_tx;

  localparam int NUM_LEDS     = 8;
  localparam int SYSTEM_CLOCK = 50000000;
  localparam int AW           = $clog2(NUM_LEDS);
  localparam int CW           = AW + 1;
  localparam int TBIT         = SYSTEM_CLOCK / 800000;
  localparam int T0H          = SYSTEM_CLOCK / 2500000;
  localparam int T1H          = SYSTEM_CLOCK / 1250000;
  localparam int TLATCH       = SYSTEM_CLOCK / 12500;

  logic          clk_i;
  logic          reset_i;
  logic          start_i;
  logic [CW-1:0] led_count_i;
  logic [7:0]    red_i, green_i, blue_i;
  logic          busy_o, data_request_o, do_o;
  logic [AW-1:0] address_o;

  neopix_tx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(SYSTEM_CLOCK)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .led_count_i    (led_count_i),
    .red_i          (red_i),
    .green_i        (green_i),
    .blue_i         (blue_i),
    .busy_o         (busy_o),
    .data_request_o (data_request_o),
    .address_o      (address_o),
    .do_o           (do_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Colour store, natural {R,G,B} order, read with one cycle of latency.
  logic [23:0] ram [NUM_LEDS];
  always @(posedge clk_i) begin
    red_i   <= ram[address_o][23:16];
    green_i <= ram[address_o][15:8];
    blue_i  <= ram[address_o][7:0];
  end

  // Line monitor: records events with the sample index at which they occur.
  int unsigned cyc = 0;
  logic        do_prev = 1'b0, busy_prev = 1'b0, req_prev = 1'b0;
  logic        req_p1 = 1'b0, req_p2 = 1'b0;
  int unsigned run_start = 0;
  int unsigned rise_q[$];
  int unsigned high_q[$];
  int unsigned brise_q[$];
  int unsigned fall_q[$];
  int unsigned req_q[$];
  int unsigned req_addr_q[$];
  int unsigned addr2_q[$];
  int          req_wide = 0;
  int          addr_over = 0;
  int          addr_lim = 1;

  always @(negedge clk_i) begin
    cyc       <= cyc + 1;
    do_prev   <= do_o;
    busy_prev <= busy_o;
    req_prev  <= data_request_o;
    req_p1    <= data_request_o;
    req_p2    <= req_p1;
    if (do_o && !do_prev) begin
      run_start <= cyc;
      rise_q.push_back(cyc);
    end
    if (!do_o && do_prev) high_q.push_back(cyc - run_start);
    if (busy_o && !busy_prev) brise_q.push_back(cyc);
    if (!busy_o && busy_prev) fall_q.push_back(cyc);
    if (data_request_o) begin
      req_q.push_back(cyc);
      req_addr_q.push_back(int'(address_o));
      if (req_prev) req_wide <= req_wide + 1;
    end
    if (req_p2) addr2_q.push_back(int'(address_o));
    if (busy_o && int'(address_o) >= addr_lim) addr_over <= addr_over + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected frame length for a requested count.
  function automatic int frame_len(input int cnt);
`ifdef NEOPIX_TX_FULL_CHAIN_EN
    if (cnt < 0) return 0;
    return NUM_LEDS;
`else
    return (cnt > NUM_LEDS) ? NUM_LEDS : cnt;
`endif
  endfunction

  int r0, h0, b0, f0, q0, a0, w0, o0;

  task automatic snapshot(input int n);
    r0 = rise_q.size();
    h0 = high_q.size();
    b0 = brise_q.size();
    f0 = fall_q.size();
    q0 = req_q.size();
    a0 = addr2_q.size();
    w0 = req_wide;
    o0 = addr_over;
    addr_lim = (n > 0) ? n : 1;
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < NUM_LEDS; i++) ram[i] = 24'($urandom);
  endtask

  task automatic start_frame(input int cnt);
    @(negedge clk_i);
    led_count_i = CW'(cnt);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
    led_count_i = CW'($urandom_range(0, 15));
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (busy_o && i < limit) begin
      @(negedge clk_i);
      i++;
    end
    check("idle_reached", busy_o, 0);
    @(negedge clk_i);
  endtask

  task automatic finish_frame(input int n);
    int          nb, nh, terr, hi, off, last;
    logic [23:0] word, e;
    wait_idle(40000);
    nb = rise_q.size() - r0;
    nh = high_q.size() - h0;
    check("bit_count", nb, 24 * n);
    check("req_count", req_q.size() - q0, n);
    check("req_width", req_wide - w0, 0);
    check("addr_bound", addr_over - o0, 0);
    if (nb == 24 * n && nh == nb && n > 0) begin
      terr = 0;
      for (int k = 0; k < n; k++) begin
        word = '0;
        for (int b = 0; b < 24; b++) begin
          hi   = int'(high_q[h0 + 24 * k + b]);
          word = {word[22:0], (hi == T1H)};
          if (hi != T1H && hi != T0H) terr++;
          off = int'(rise_q[r0 + 24 * k + b] - rise_q[r0]);
          if (off != (24 * k + b) * TBIT + 2 * k) terr++;
        end
        e = ram[k];
        check("led_grb", word, {e[15:8], e[23:16], e[7:0]});
      end
      check("bit_timing", terr, 0);
    end
    if (req_addr_q.size() - q0 == n && addr2_q.size() - a0 == n) begin
      for (int k = 0; k < n; k++) begin
        check("req_addr", req_addr_q[q0 + k], k);
        check("addr_step", addr2_q[a0 + k], (k + 1 < n) ? k + 1 : k);
      end
    end
    if (brise_q.size() > b0 && fall_q.size() > f0) begin
      if (n > 0 && nb > 0) begin
        last = int'(rise_q[r0 + nb - 1]);
        check("lead_in", rise_q[r0] - brise_q[b0], 3);
        check("latch_len", int'(fall_q[f0]) - last, TBIT + TLATCH);
      end else if (n == 0) begin
        off = int'(fall_q[f0] - brise_q[b0]);
        check("empty_busy_len", (off == TLATCH || off == TLATCH + 1), 1);
      end
    end else begin
      check("busy_edges_seen", 0, 1);
    end
    check("idle_addr", address_o, 0);
    check("idle_do", do_o, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, n, rr, i;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    led_count_i = '0;
    randomize_ram();
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_do", do_o, 0);
    check("rst_req", data_request_o, 0);
    check("rst_addr", address_o, 0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single LED, R00 G80 B01.
    ram[0] = 24'h008001;
    n = frame_len(1);
    snapshot(n);
    start_frame(1);
    finish_frame(n);
    if (high_q.size() >= h0 + 24 && rise_q.size() >= r0 + 2) begin
      check("t1_first_hi", high_q[h0], T1H);
      check("t1_first_lo", int'(rise_q[r0 + 1] - rise_q[r0] - high_q[h0]), TBIT - T1H);
      check("t1_mid_hi", high_q[h0 + 1], T0H);
      check("t1_last_hi", high_q[h0 + 23], T1H);
    end else begin
      check("t1_bits_present", 0, 1);
    end

    // Three LEDs with random colours.
    randomize_ram();
    n = frame_len(3);
    snapshot(n);
    start_frame(3);
    finish_frame(n);

    // Empty frame: latch only.
    n = frame_len(0);
    snapshot(n);
    start_frame(0);
    finish_frame(n);

    // Over-long count clamps to NUM_LEDS.
    randomize_ram();
    n = frame_len(12);
    snapshot(n);
    start_frame(12);
    finish_frame(n);

    // Reset during bit 10 of the second LED.
    randomize_ram();
    n = frame_len(2);
    snapshot(n);
    start_frame(2);
    i = 0;
    while (rise_q.size() - r0 < 35 && i < 5000) begin
      @(negedge clk_i);
      i++;
    end
    check("rst_point_reached", (rise_q.size() - r0 >= 35), 1);
    @(negedge clk_i);
    #1;
    check("pre_rst_do", do_o, 1);
    reset_i = 1'b1;
    #1;
    check("async_do", do_o, 0);
    check("async_busy", busy_o, 0);
    check("async_req", data_request_o, 0);
    check("async_addr", address_o, 0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    rr = rise_q.size();
    repeat (100) @(negedge clk_i);
    check("no_resume_do", rise_q.size() - rr, 0);
    check("post_rst_busy", busy_o, 0);

    // Fresh frame after reset, with a stray start while transmitting.
    randomize_ram();
    cnt = $urandom_range(2, 3);
    n = frame_len(cnt);
    snapshot(n);
    start_frame(cnt);
    repeat (300) @(negedge clk_i);
    led_count_i = CW'(7);
    start_i     = 1'b1;
    repeat (2) @(negedge clk_i);
    start_i     = 1'b0;
    finish_frame(n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/neopix_tx.md
NEOPIX_TX -- requirements
Module: neopix_tx

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: maximum LEDs per frame.
REQ-002 SHALL have parameter SYSTEM_CLOCK, default 50000000: clk_i frequency in Hz.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port start_i  input  1  frame start request, level-sampled.
REQ-006 SHALL have port led_count_i  input  $clog2(NUM_LEDS)+1  LEDs to send this frame.
REQ-007 SHALL have port red_i, green_i, blue_i  input  8 each  pixel colour for address_o.
REQ-008 SHALL have port busy_o  output  1  frame in progress.
REQ-009 SHALL have port data_request_o  output  1  one-cycle pulse; colour sampled next cycle.
REQ-010 SHALL have port address_o  output  $clog2(NUM_LEDS)  current LED index.
REQ-011 SHALL have port do_o  output  1  WS2812 serial line.

Function
REQ-012 Timing constants (integer division): TBIT=SYSTEM_CLOCK/800000, T0H=SYSTEM_CLOCK/2500000, T1H=SYSTEM_CLOCK/1250000, TLATCH=SYSTEM_CLOCK/12500; at 50 MHz: 62/20/40/4000 cycles.
REQ-013 States: IDLE, PREP, REQ, LOAD, BIT, LATCH.
REQ-014 IDLE: busy_o=0, do_o=0, address_o=0; start_i=1 at an edge -> PREP, busy_o=1 from the next cycle.
REQ-015 Frame length N=min(led_count_i, NUM_LEDS), latched at the start edge; later led_count_i changes ignored.
REQ-016 N=0 -> IDLE goes directly to LATCH; no data_request_o pulse.
REQ-017 PREP: one cycle, address_o stable at 0 for downstream RAM latency -> REQ.
REQ-018 REQ: data_request_o=1 for exactly one cycle -> LOAD.
REQ-019 LOAD: 24-bit shift register <= {green_i, red_i, blue_i}; at the closing edge address_o increments if more LEDs remain, i.e. two cycles after the REQ cycle -> BIT.
REQ-020 BIT: bit counter 0..23, sent MSB first (G7 first, B0 last); per bit a cycle counter runs 0..TBIT-1, do_o=1 while count < T1H (bit=1) or < T0H (bit=0), else 0.
REQ-021 After bit 23: LEDs remaining -> REQ; else -> LATCH; REQ/LOAD between LEDs hold do_o=0 (2-cycle low extension, permitted).
REQ-022 LATCH: do_o=0 for TLATCH cycles, then IDLE, address_o <= 0, busy_o=0.
REQ-023 start_i while busy_o=1 SHALL be ignored; start_i held high restarts a new frame the cycle after IDLE is re-entered.
REQ-024 Counters SHALL be sized for the parameters without wrap; address_o never exceeds N-1.

Reset
REQ-025 reset_i=1 SHALL immediately force IDLE, do_o=0, busy_o=0, data_request_o=0, address_o=0, clear shift register and counters.
REQ-026 Reset mid-frame SHALL abort the frame; no partial bit continues after release; the next start_i begins a full new frame.

Configuration
REQ-027 Macro NEOPIX_TX_FULL_CHAIN_EN: when defined, N=NUM_LEDS regardless of led_count_i (upstream pads unused pixels); when undefined, REQ-015/REQ-016 apply.

Verification (SYSTEM_CLOCK=50000000, NUM_LEDS=8, macro undefined unless stated)
REQ-028 led_count_i=1, rgb=R00 G80 B01, start pulse -> do_o: first bit high 40 cycles, low 22; next 22 bits high 20; last bit high 40; then 4000-cycle low; busy_o falls; one data_request_o pulse.
REQ-029 led_count_i=3, RAM model with 1-cycle latency -> 3 data_request_o pulses; address_o 0,1,2 rising two cycles after each pulse except the last; 72 bits on do_o.
REQ-030 led_count_i=0, start -> no data_request_o, do_o stays 0, busy_o high exactly 4000 cycles (+1 entry cycle).
REQ-031 led_count_i=12 -> clamped to 8 LEDs, 192 bits; macro defined with led_count_i=2 -> 8 LEDs, 192 bits.
REQ-032 Assert reset_i during bit 10 of LED 1 -> do_o, busy_o 0 within same cycle (asynchronous); new start after release -> frame restarts at address_o=0.
REQ-033 Second start_i pulse during BIT -> ignored; frame length and timing unchanged.
